// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b transmit PCS: MII control
// characters, 7-bit control codes, block types, sync headers and FSM/class enums.
package pcs_pkg;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;

  localparam logic [6:0] C7_IDLE  = 7'h00;
  localparam logic [6:0] C7_ERROR = 7'h1E;

  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_S4 = 8'h33;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'hAA;
  localparam logic [7:0] BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC;
  localparam logic [7:0] BT_T5 = 8'hD2;
  localparam logic [7:0] BT_T6 = 8'hE1;
  localparam logic [7:0] BT_T7 = 8'hFF;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [65:0] IDLE_BLOCK  = {56'h0, BT_C, SYNC_CTRL};
  localparam logic [65:0] ERROR_BLOCK = {{8{C7_ERROR}}, BT_C, SYNC_CTRL};

  typedef enum logic [2:0] {
    TX_INIT = 3'd0,
    TX_C    = 3'd1,
    TX_D    = 3'd2,
    TX_T    = 3'd3,
    TX_E    = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    WC_C  = 3'd0,
    WC_S0 = 3'd1,
    WC_S4 = 3'd2,
    WC_D  = 3'd3,
    WC_T  = 3'd4,
    WC_E  = 3'd5
  } word_class_t;

  // Only idle and error are legal in a control position; anything else
  // would already have made the word an E word.
  function automatic logic is_c_char(input logic [7:0] b);
    return (b == CH_IDLE) || (b == CH_ERROR);
  endfunction

  function automatic logic [6:0] ctrl_code(input logic [7:0] b);
    return (b == CH_IDLE) ? C7_IDLE : C7_ERROR;
  endfunction

  function automatic logic [7:0] term_type(input logic [2:0] k);
    logic [7:0] t;
    case (k)
      3'd0:    t = BT_T0;
      3'd1:    t = BT_T1;
      3'd2:    t = BT_T2;
      3'd3:    t = BT_T3;
      3'd4:    t = BT_T4;
      3'd5:    t = BT_T5;
      3'd6:    t = BT_T6;
      default: t = BT_T7;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pcs_66b_classify.sv
// Combinational classifier: decides which block format an 8-lane MII word
// maps to and, for terminate words, which lane carries /T/.
module pcs_66b_classify
  import pcs_pkg::*;
(
  input  logic [63:0] i_txd,
  input  logic [7:0]  i_txc,
  output word_class_t o_class,
  output logic [2:0]  o_term_lane
);

  logic [7:0] w_cc;
  logic       w_found;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_cc[i] = is_c_char(i_txd[8*i +: 8]);
    end
  end

  always_comb begin
    o_class     = WC_E;
    o_term_lane = 3'd0;
    w_found     = 1'b0;
    if (i_txc == 8'h00) begin
      o_class = WC_D;
    end else if ((i_txc == 8'hFF) && (&w_cc)) begin
      o_class = WC_C;
    end else if ((i_txc == 8'h01) && (i_txd[7:0] == CH_START)) begin
      o_class = WC_S0;
    end else if ((i_txc == 8'h1F) && (&w_cc[3:0]) && (i_txd[39:32] == CH_START)) begin
      o_class = WC_S4;
    end else begin
      // Lane k holds /T/, lanes above it are control, lanes below are data.
      for (int k = 0; k < 8; k++) begin
        if (!w_found && (i_txd[8*k +: 8] == CH_TERM) &&
            (i_txc == (8'hFF << k)) && (&(w_cc | ~(8'hFE << k)))) begin
          w_found     = 1'b1;
          o_class     = WC_T;
          o_term_lane = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pcs_64b66b_encoder.sv
// 64b/66b transmit encoder: classifies each MII word, tracks the transmit
// state machine and emits one 66-bit block (unscrambled) one cycle later.
module pcs_64b66b_encoder
  import pcs_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_txd,
  input  logic [7:0]  i_txc,
  output logic        o_valid,
  output logic [65:0] o_block,
  output logic [15:0] o_err_cnt,
  output tx_state_t   o_dbg_state
);

  // Handshake: valid-only stream, no backpressure. A word is consumed on every
  // clk edge with i_valid=1; o_valid pulses for exactly one cycle per word.

  word_class_t w_class;
  logic [2:0]  w_term_lane;
  tx_state_t   r_state;
  tx_state_t   w_next_state;
  logic [63:0] w_payload;
  logic [65:0] w_enc_block;
  logic [65:0] w_block;
  logic        w_err;
  logic        r_valid;
  logic [65:0] r_block;
  logic [15:0] r_err_cnt;

  pcs_66b_classify u_classify (
    .i_txd       (i_txd),
    .i_txc       (i_txc),
    .o_class     (w_class),
    .o_term_lane (w_term_lane)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TX_INIT;
    end else if (i_valid) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = TX_E;
    case (r_state)
      TX_INIT, TX_C, TX_T: begin
        if (w_class == WC_C)                            w_next_state = TX_C;
        else if ((w_class == WC_S0) || (w_class == WC_S4)) w_next_state = TX_D;
        else                                            w_next_state = TX_E;
      end
      TX_D: begin
        // A start inside a packet is illegal; a terminate right after a start is fine.
        if (w_class == WC_D)      w_next_state = TX_D;
        else if (w_class == WC_T) w_next_state = TX_T;
        else                      w_next_state = TX_E;
      end
      TX_E: begin
        case (w_class)
          WC_C:               w_next_state = TX_C;
          WC_S0, WC_S4, WC_D: w_next_state = TX_D;
          WC_T:               w_next_state = TX_T;
          default:            w_next_state = TX_E;
        endcase
      end
      default: w_next_state = TX_E;
    endcase
  end

  // Control fields always sit at P[8+7m], data lanes at P[8m] for start
  // blocks and P[8+8m] for terminate blocks; the rest is zero fill.
  always_comb begin
    w_payload = 64'h0;
    case (w_class)
      WC_C: begin
        w_payload[7:0] = BT_C;
        for (int m = 0; m < 8; m++) begin
          w_payload[8+7*m +: 7] = ctrl_code(i_txd[8*m +: 8]);
        end
      end
      WC_S0: begin
        w_payload = {i_txd[63:8], BT_S0};
      end
      WC_S4: begin
        w_payload[7:0] = BT_S4;
        for (int m = 0; m < 4; m++) begin
          w_payload[8+7*m +: 7] = ctrl_code(i_txd[8*m +: 8]);
        end
        w_payload[63:40] = i_txd[63:40];
      end
      WC_T: begin
        w_payload[7:0] = term_type(w_term_lane);
        for (int m = 0; m < 7; m++) begin
          if (3'(m) < w_term_lane) w_payload[8+8*m +: 8] = i_txd[8*m +: 8];
        end
        for (int m = 1; m < 8; m++) begin
          if (3'(m) > w_term_lane) w_payload[8+7*m +: 7] = ctrl_code(i_txd[8*m +: 8]);
        end
      end
      default: w_payload = 64'h0;
    endcase
  end

  always_comb begin
    if (w_class == WC_D) w_enc_block = {i_txd, SYNC_DATA};
    else                 w_enc_block = {w_payload, SYNC_CTRL};
  end

  always_comb begin
    w_err   = (w_next_state == TX_E);
    w_block = w_err ? ERROR_BLOCK : w_enc_block;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_block   <= IDLE_BLOCK;
      r_err_cnt <= 16'h0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_block <= w_block;
        if (w_err && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_block     = r_block;
  assign o_err_cnt   = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pcs_64b66b_encoder.sv
// Bench for pcs_64b66b_encoder: directed and random MII words, expected blocks
// from a field-appending reference model, checked by a queue-based monitor.
module tb_pcs_64b66b_encoder;
  import pcs_pkg::*;

  localparam int EXP_W = 66 + 16 + 3;
  localparam int K_C = 0, K_S0 = 1, K_S4 = 2, K_D = 3, K_T = 4, K_E = 5;
  localparam logic [7:0] T_TYPE [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  localparam logic [65:0] L_IDLE = {56'h0, 8'h1E, 2'b10};
  localparam logic [65:0] L_ERR  = {{8{7'h1E}}, 8'h1E, 2'b10};

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [63:0] i_txd;
  logic [7:0]  i_txc;
  logic        o_valid;
  logic [65:0] o_block;
  logic [15:0] o_err_cnt;
  tx_state_t   o_dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  tx_state_t   m_state;
  logic [15:0] m_err;
  logic [65:0] m_last;

  pcs_64b66b_encoder dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_txd       (i_txd),
    .i_txc       (i_txc),
    .o_valid     (o_valid),
    .o_block     (o_block),
    .o_err_cnt   (o_err_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit tb_cc(input logic [7:0] b);
    return (b == 8'h07) || (b == 8'hFE);
  endfunction

  function automatic logic [7:0] code7(input logic [7:0] b);
    return (b == 8'h07) ? 8'h00 : 8'h1E;
  endfunction

  function automatic logic [63:0] put(input logic [63:0] p, input logic [7:0] v,
                                      input int w, input int pos);
    return p | ((64'(v) & ((64'd1 << w) - 64'd1)) << pos);
  endfunction

  function automatic void m_classify(input logic [63:0] d, input logic [7:0] c,
                                     output int kind, output int k);
    logic [7:0] b [8];
    bit all_cc;
    bit ok;
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    kind = K_E;
    k = 0;
    all_cc = 1'b1;
    for (int i = 0; i < 8; i++) all_cc = all_cc & tb_cc(b[i]);
    if (c == 8'h00) kind = K_D;
    else if (c == 8'hFF && all_cc) kind = K_C;
    else if (c == 8'h01 && b[0] == 8'hFB) kind = K_S0;
    else if (c == 8'h1F && tb_cc(b[0]) && tb_cc(b[1]) && tb_cc(b[2]) && tb_cc(b[3]) &&
             b[4] == 8'hFB) kind = K_S4;
    else begin
      for (int t = 0; t < 8; t++) begin
        ok = (b[t] == 8'hFD) && (c == 8'(8'hFF << t));
        for (int j = t + 1; j < 8; j++) ok = ok & tb_cc(b[j]);
        if (ok) begin
          kind = K_T;
          k = t;
        end
      end
    end
  endfunction

  // Builds the payload by appending fields from P[0] upward.
  function automatic logic [65:0] m_encode(input logic [63:0] d, input int kind, input int k);
    logic [63:0] p;
    int pos;
    p = 64'h0;
    pos = 0;
    case (kind)
      K_D: return {d, 2'b01};
      K_C: begin
        p = put(p, 8'h1E, 8, pos); pos += 8;
        for (int i = 0; i < 8; i++) begin p = put(p, code7(d[8*i +: 8]), 7, pos); pos += 7; end
      end
      K_S0: begin
        p = put(p, 8'h78, 8, pos); pos += 8;
        for (int i = 1; i < 8; i++) begin p = put(p, d[8*i +: 8], 8, pos); pos += 8; end
      end
      K_S4: begin
        p = put(p, 8'h33, 8, pos); pos += 8;
        for (int i = 0; i < 4; i++) begin p = put(p, code7(d[8*i +: 8]), 7, pos); pos += 7; end
        pos += 4;
        for (int i = 5; i < 8; i++) begin p = put(p, d[8*i +: 8], 8, pos); pos += 8; end
      end
      K_T: begin
        p = put(p, T_TYPE[k], 8, pos); pos += 8;
        for (int i = 0; i < k; i++) begin p = put(p, d[8*i +: 8], 8, pos); pos += 8; end
        pos += 7 - k;
        for (int i = k + 1; i < 8; i++) begin p = put(p, code7(d[8*i +: 8]), 7, pos); pos += 7; end
      end
      default: return L_ERR;
    endcase
    return {p, 2'b10};
  endfunction

  function automatic tx_state_t m_next(input tx_state_t s, input int kind);
    case (s)
      TX_D: return (kind == K_D) ? TX_D : (kind == K_T) ? TX_T : TX_E;
      TX_E: begin
        if (kind == K_C) return TX_C;
        if (kind == K_S0 || kind == K_S4 || kind == K_D) return TX_D;
        if (kind == K_T) return TX_T;
        return TX_E;
      end
      default: begin
        if (kind == K_C) return TX_C;
        if (kind == K_S0 || kind == K_S4) return TX_D;
        return TX_E;
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] d, input logic [7:0] c,
                      input bit use_lit, input logic [65:0] lit);
    int kind;
    int k;
    logic [65:0] blk;
    m_classify(d, c, kind, k);
    m_state = m_next(m_state, kind);
    if (m_state == TX_E) begin
      blk = L_ERR;
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end else begin
      blk = m_encode(d, kind, k);
    end
    if (use_lit) blk = lit;
    m_last = blk;
    exp_q.push_back({blk, m_err, 3'(m_state)});
    i_txd = d;
    i_txc = c;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b0;
      i_txd = {$urandom, $urandom};
      i_txc = 8'($urandom);
      @(posedge clk);
      #1;
      check("idle_valid", 66'(o_valid), 66'd0);
      check("idle_block_hold", o_block, m_last);
      check("idle_err_hold", 66'(o_err_cnt), 66'(m_err));
    end
  endtask

  task automatic chk_reset();
    check("rst_valid", 66'(o_valid), 66'd0);
    check("rst_block", o_block, L_IDLE);
    check("rst_err_cnt", 66'(o_err_cnt), 66'd0);
    check("rst_state", 66'(o_dbg_state), 66'(TX_INIT));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk_reset();
    m_state = TX_INIT;
    m_err = 16'h0;
    m_last = L_IDLE;
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_cc();
    return ($urandom_range(0, 1) == 0) ? 8'h07 : 8'hFE;
  endfunction

  task automatic gen_word(input int kind, output logic [63:0] d, output logic [7:0] c);
    int k;
    d = {$urandom, $urandom};
    c = 8'($urandom);
    case (kind)
      K_C: begin for (int i = 0; i < 8; i++) d[8*i +: 8] = rnd_cc(); c = 8'hFF; end
      K_S0: begin d[7:0] = 8'hFB; c = 8'h01; end
      K_S4: begin
        for (int i = 0; i < 4; i++) d[8*i +: 8] = rnd_cc();
        d[39:32] = 8'hFB;
        c = 8'h1F;
      end
      K_D: c = 8'h00;
      K_T: begin
        k = $urandom_range(0, 7);
        d[8*k +: 8] = 8'hFD;
        for (int i = k + 1; i < 8; i++) d[8*i +: 8] = rnd_cc();
        c = 8'(8'hFF << k);
      end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (i_rst_n && o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 66'(o_valid), 66'd0);
        end else begin
          e = exp_q.pop_front();
          check("block", o_block, e[EXP_W-1 -: 66]);
          check("err_cnt", 66'(o_err_cnt), 66'(e[18:3]));
          check("state", 66'(o_dbg_state), 66'(e[2:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d;
    logic [7:0] c;
    int kind;
    int r;
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_txd = 64'h0;
    i_txc = 8'h0;
    m_state = TX_INIT;
    m_err = 16'h0;
    m_last = L_IDLE;
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(64'h0707070707070707, 8'hFF, 1, L_IDLE);
    send(64'hD5555555555555FB, 8'h01, 1, {56'hD5555555555555, 8'h78, 2'b10});
    send(64'h07070707FD332211, 8'hF8, 1, {32'h0, 24'h332211, 8'hB4, 2'b10});
    send(64'hD5555555555555FB, 8'h01, 1, {56'hD5555555555555, 8'h78, 2'b10});
    send(64'h07070707070707FD, 8'hFF, 1, {56'h0, 8'h87, 2'b10});
    send(64'h0707070707070707, 8'hFF, 1, L_IDLE);
    send(64'h0123456789ABCDEF, 8'h00, 1, L_ERR);
    send(64'h0707070707070707, 8'hFF, 1, L_IDLE);

    send(64'hD5555555555555FB, 8'h01, 0, '0);
    send(64'h1122334455667788, 8'h00, 1, {64'h1122334455667788, 2'b01});
    idle(3);
    send(64'h99AABBCCDDEEFF00, 8'h00, 1, {64'h99AABBCCDDEEFF00, 2'b01});
    send(64'hFD11223344556677, 8'h80, 0, '0);
    send(64'h0707070707070707, 8'hFF, 0, '0);

    send(64'hD5555555555555FB, 8'h01, 0, '0);
    send(64'h555555FB07070707, 8'h1F, 1, L_ERR);
    send(64'h555555FB07070707, 8'h1F, 0, '0);
    send(64'h07070707FD332211, 8'hF8, 0, '0);

    send(64'hD5555555555555FB, 8'h01, 0, '0);
    send(64'h1122334455667788, 8'h00, 0, '0);
    do_reset();
    send(64'h1122334455667788, 8'h00, 1, L_ERR);
    send(64'h0707070707070707, 8'hFF, 1, L_IDLE);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 2));
      end else begin
        r = $urandom_range(0, 9);
        case (m_state)
          TX_D: kind = (r < 6) ? K_D : (r < 9) ? K_T : $urandom_range(0, 5);
          TX_E: kind = $urandom_range(0, 5);
          default: kind = (r < 6) ? K_C : (r < 8) ? $urandom_range(1, 2) : $urandom_range(0, 5);
        endcase
        gen_word(kind, d, c);
        send(d, c, 0, '0);
      end
    end

    do_reset();
    for (int n = 0; n < 65537; n++) begin
      send({$urandom, $urandom}, 8'hAA, 0, '0);
    end
    @(negedge clk);
    #1;
    check("err_cnt_saturated", 66'(o_err_cnt), 66'h0FFFF);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 66'(exp_q.size()), 66'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
